// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: issues data-memory loads/stores over req/gnt/rvalid, stalls EX via
// busywait_o while an access is outstanding, and drives the MEM/WB register.
module memory_access_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  rd_ex_mem_i,
   input  logic [31:0] pc_ex_mem_i,
   input  logic [1:0]  wb_sel_ex_mem_i,
   input  logic [31:0] alu_out_ex_mem_i,
   input  logic [31:0] rs2_ex_mem_i,
   input  logic [2:0]  funct3_ex_mem_i,
   input  logic        is_load_instr_ex_mem_i,
   input  logic        is_store_instr_ex_mem_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        busywait_o,
   output logic [4:0]  rd_mem_wb_o,
   output logic [31:0] pc_mem_wb_o,
   output logic [1:0]  wb_sel_mem_wb_o,
   output logic [31:0] alu_out_mem_wb_o,
   output logic [31:0] rd_data_mem_wb_o,
   output logic        is_load_instr_mem_wb_o,
   output logic        misaligned_o,
   output logic        bus_error_o,
   output logic [1:0]  state_dbg_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RSP = 2'd1, DONE = 2'd2} state_e;

   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
   localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

   state_e      state_q, state_d;
   logic [31:0] done_pc_q, done_pc_d, cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pc_q, pc_d, alu_q, alu_d, rd_data_q, rd_data_d;
   logic [1:0]  wb_sel_q, wb_sel_d;
   logic        is_load_q, is_load_d, misaligned_q, misaligned_d, bus_error_q, bus_error_d;

   logic        mem_raw, same_pc, eff_idle, in_wait, misaligned, issue, timeout, rsp, abort_acc;
   logic        busy, wb_valid;
   logic [31:0] shifted, load_data, wdata;
   logic [3:0]  be_st;

   always_comb begin
      mem_raw    = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;
      same_pc    = (state_q == DONE) && (pc_ex_mem_i == done_pc_q);
      eff_idle   = (state_q == IDLE) || ((state_q == DONE) && !same_pc);
      in_wait    = (state_q == WAIT_RSP);
      misaligned = ((funct3_ex_mem_i[1:0] == 2'b01) && alu_out_ex_mem_i[0]) ||
                   ((funct3_ex_mem_i[1:0] == 2'b10) && (alu_out_ex_mem_i[1:0] != 2'b00));
      issue      = eff_idle && mem_raw && !misaligned;
      timeout    = TIMEOUT_EN && (cnt_q >= TIMEOUT_LIM);
      rsp        = in_wait && dmem_rvalid_i;
      abort_acc  = in_wait && !dmem_rvalid_i && timeout;
      busy       = issue || (in_wait && !dmem_rvalid_i && !timeout);
      wb_valid   = !busy && ((eff_idle && !mem_raw) || rsp);
   end

   // Load alignment/extension and store lane replication.
   always_comb begin
      shifted = dmem_rdata_i >> {alu_out_ex_mem_i[1:0], 3'b000};
      case (funct3_ex_mem_i)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
      case (funct3_ex_mem_i[1:0])
         2'b00: begin
            wdata = {4{rs2_ex_mem_i[7:0]}};
            be_st = 4'b0001 << alu_out_ex_mem_i[1:0];
         end
         2'b01: begin
            wdata = {2{rs2_ex_mem_i[15:0]}};
            be_st = 4'b0011 << {alu_out_ex_mem_i[1], 1'b0};
         end
         default: begin
            wdata = rs2_ex_mem_i;
            be_st = 4'b1111;
         end
      endcase
   end

   // req/gnt: req is held with stable fields until gnt; a transfer happens when both are high.
   // rvalid then completes the single outstanding access; it is only honoured in WAIT_RSP.
   always_comb begin
      dmem_req_o   = issue;
      dmem_we_o    = issue && is_store_instr_ex_mem_i;
      dmem_addr_o  = issue ? {alu_out_ex_mem_i[31:2], 2'b00} : 32'd0;
      dmem_be_o    = !issue ? 4'b0000 : (is_store_instr_ex_mem_i ? be_st : 4'b1111);
      dmem_wdata_o = (issue && is_store_instr_ex_mem_i) ? wdata : 32'd0;
      busywait_o   = busy;
   end

   always_comb begin
      state_d = state_q;
      if (issue && dmem_gnt_i)   state_d = WAIT_RSP;
      else if (rsp || abort_acc) state_d = DONE;
      else if (eff_idle)         state_d = IDLE;
      done_pc_d    = (rsp || abort_acc) ? pc_ex_mem_i : done_pc_q;
      cnt_d        = busy ? cnt_q + 32'd1 : 32'd0;
      rd_d         = wb_valid ? rd_ex_mem_i : 5'd0;
      pc_d         = wb_valid ? pc_ex_mem_i : 32'd0;
      wb_sel_d     = wb_valid ? wb_sel_ex_mem_i : 2'd0;
      alu_d        = wb_valid ? alu_out_ex_mem_i : 32'd0;
      is_load_d    = wb_valid && is_load_instr_ex_mem_i;
      rd_data_d    = (wb_valid && rsp && is_load_instr_ex_mem_i) ? load_data : 32'd0;
      misaligned_d = eff_idle && mem_raw && misaligned;
      bus_error_d  = abort_acc;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         done_pc_q    <= 32'd0;
         cnt_q        <= 32'd0;
         rd_q         <= 5'd0;
         pc_q         <= 32'd0;
         wb_sel_q     <= 2'd0;
         alu_q        <= 32'd0;
         rd_data_q    <= 32'd0;
         is_load_q    <= 1'b0;
         misaligned_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_pc_q    <= done_pc_d;
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         pc_q         <= pc_d;
         wb_sel_q     <= wb_sel_d;
         alu_q        <= alu_d;
         rd_data_q    <= rd_data_d;
         is_load_q    <= is_load_d;
         misaligned_q <= misaligned_d;
         bus_error_q  <= bus_error_d;
      end
   end

   assign rd_mem_wb_o            = rd_q;
   assign pc_mem_wb_o            = pc_q;
   assign wb_sel_mem_wb_o        = wb_sel_q;
   assign alu_out_mem_wb_o       = alu_q;
   assign rd_data_mem_wb_o       = rd_data_q;
   assign is_load_instr_mem_wb_o = is_load_q;
   assign misaligned_o           = misaligned_q;
   assign bus_error_o            = bus_error_q;
   assign state_dbg_o            = state_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed and randomized checks of memory_access_stage against an arithmetic reference model.
module tb_memory_access_stage;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]  rd_i;
   logic [31:0] pc_i, alu_i, rs2_i, rdata;
   logic [1:0]  wb_sel_i;
   logic [2:0]  f3_i;
   logic        ld_i, st_i, gnt, rvalid;
   logic        req, we, busy, is_load_wb, mis, berr;
   logic [31:0] addr, wdata, pc_wb, alu_wb, rd_data_wb;
   logic [3:0]  be;
   logic [4:0]  rd_wb;
   logic [1:0]  wb_sel_wb, state_dbg;

   memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .rd_ex_mem_i(rd_i), .pc_ex_mem_i(pc_i), .wb_sel_ex_mem_i(wb_sel_i),
      .alu_out_ex_mem_i(alu_i), .rs2_ex_mem_i(rs2_i), .funct3_ex_mem_i(f3_i),
      .is_load_instr_ex_mem_i(ld_i), .is_store_instr_ex_mem_i(st_i),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
      .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .busywait_o(busy), .rd_mem_wb_o(rd_wb), .pc_mem_wb_o(pc_wb),
      .wb_sel_mem_wb_o(wb_sel_wb), .alu_out_mem_wb_o(alu_wb), .rd_data_mem_wb_o(rd_data_wb),
      .is_load_instr_mem_wb_o(is_load_wb), .misaligned_o(mis), .bus_error_o(berr),
      .state_dbg_o(state_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on byte offsets.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] sh, b, h;
      sh = w / (32'd1 << (8 * (a % 4)));
      b  = sh % 256;
      h  = sh % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a, input logic is_st);
      if (!is_st) return 32'd15;
      case (f3 % 4)
         0:       return 32'd1 << (a % 4);
         1:       return 32'd3 << ((a % 4) / 2 * 2);
         default: return 32'd15;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3 % 4)
         0:       return (d % 256) * 32'h0101_0101;
         1:       return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   task automatic set_instr(input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] ws,
                            input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                            input logic ld, input logic st);
      rd_i = rd; pc_i = pc; wb_sel_i = ws; alu_i = alu; rs2_i = rs2; f3_i = f3; ld_i = ld; st_i = st;
   endtask

   // Responder: gnt after gd cycles, rvalid rd_dly cycles later; checks every cycle and MEM/WB after.
   task automatic run_access(input int gd, input int rd_dly, input logic [31:0] word);
      int total;
      total = gd + rd_dly;
      for (int c = 0; c <= total; c++) begin
         gnt = (c == gd);
         rvalid = (c == total);
         rdata = (c == total) ? word : $urandom;
         @(negedge clk);
         check("busywait", busy, c < total);
         check("req", req, c <= gd);
         if (c <= gd) begin
            check("addr", addr, alu_i & 32'hFFFF_FFFC);
            check("we", we, st_i);
            check("be", be, ref_be(f3_i, alu_i, st_i));
            if (st_i) check("wdata", wdata, ref_wdata(f3_i, rs2_i));
         end
         @(posedge clk); #1;
         gnt = 1'b0; rvalid = 1'b0;
         if (c < total) check("stall_bubble_rd", rd_wb, 0);
      end
      check("wb_rd", rd_wb, rd_i);
      check("wb_pc", pc_wb, pc_i);
      check("wb_sel", wb_sel_wb, wb_sel_i);
      check("wb_alu", alu_wb, alu_i);
      check("wb_is_load", is_load_wb, ld_i);
      check("wb_rd_data", rd_data_wb, ld_i ? ref_load(f3_i, alu_i, word) : 32'd0);
      check("state_done", state_dbg, 2);
      check("no_bus_error", berr, 0);
   endtask

   task automatic run_nonmem();
      @(negedge clk);
      check("nm_busy", busy, 0);
      check("nm_req", req, 0);
      @(posedge clk); #1;
      check("nm_rd", rd_wb, rd_i);
      check("nm_pc", pc_wb, pc_i);
      check("nm_alu", alu_wb, alu_i);
      check("nm_wb_sel", wb_sel_wb, wb_sel_i);
      check("nm_rd_data", rd_data_wb, 0);
   endtask

   initial begin
      logic [31:0] pc, a;
      logic [2:0]  f3;
      int          kind;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      gnt = 0; rvalid = 0; rdata = 0;
      #12;
      check("rst_state", state_dbg, 0);
      check("rst_req", req, 0);
      check("rst_busy", busy, 0);
      check("rst_rd", rd_wb, 0);
      check("rst_pc", pc_wb, 0);
      check("rst_alu", alu_wb, 0);
      check("rst_rd_data", rd_data_wb, 0);
      check("rst_mis", mis, 0);
      check("rst_berr", berr, 0);
      @(posedge clk); #1;
      rst_ni = 1'b1;

      set_instr(5, 32'h100, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      run_nonmem();

      // LB sign extension, then hold the instruction to see it suppressed in DONE.
      set_instr(3, 32'h104, 2, 32'h1002, 0, 3'b000, 1, 0);
      run_access(0, 1, 32'h80FF_7F00);
      check("lb_value", rd_data_wb, 32'hFFFF_FFFF);
      @(negedge clk);
      check("done_busy", busy, 0);
      check("done_req", req, 0);
      @(posedge clk); #1;
      check("done_bubble_rd", rd_wb, 0);
      check("done_bubble_ld", is_load_wb, 0);
      check("done_state", state_dbg, 2);

      set_instr(3, 32'h108, 2, 32'h1002, 0, 3'b100, 1, 0);
      run_access(0, 1, 32'h80FF_7F00);
      check("lbu_value", rd_data_wb, 32'h0000_00FF);

      set_instr(0, 32'h10C, 0, 32'h2002, 32'h1234_ABCD, 3'b001, 0, 1);
      run_access(0, 1, 32'h0);

      // Misaligned LW: no request, no stall, one-cycle pulse.
      set_instr(7, 32'h110, 2, 32'h3001, 0, 3'b010, 1, 0);
      @(negedge clk);
      check("mis_req", req, 0);
      check("mis_busy", busy, 0);
      @(posedge clk); #1;
      check("mis_pulse", mis, 1);
      check("mis_rd", rd_wb, 0);
      check("mis_ld", is_load_wb, 0);
      set_instr(8, 32'h114, 1, 32'h55, 0, 0, 0, 0);
      run_nonmem();
      check("mis_clear", mis, 0);

      // Delayed gnt and rvalid: four stall cycles.
      set_instr(9, 32'h118, 2, 32'h5000, 0, 3'b010, 1, 0);
      run_access(2, 2, 32'hCAFE_F00D);

      // Timeout with no response, then a late rvalid, then a fresh load.
      set_instr(10, 32'h11C, 2, 32'h4000, 0, 3'b010, 1, 0);
      for (int c = 0; c <= 4; c++) begin
         gnt = (c == 0);
         @(negedge clk);
         check("to_busy", busy, c < 4);
         check("to_req", req, c == 0);
         @(posedge clk); #1;
         gnt = 1'b0;
         if (c < 4) check("to_no_berr", berr, 0);
      end
      check("to_berr", berr, 1);
      check("to_state", state_dbg, 2);
      check("to_rd", rd_wb, 0);
      check("to_ld", is_load_wb, 0);
      rvalid = 1'b1; rdata = 32'h1111_2222;
      @(negedge clk);
      check("late_busy", busy, 0);
      check("late_req", req, 0);
      @(posedge clk); #1;
      rvalid = 1'b0;
      check("late_rd", rd_wb, 0);
      check("late_berr", berr, 0);
      check("late_state", state_dbg, 2);
      set_instr(11, 32'h120, 2, 32'h4004, 0, 3'b010, 1, 0);
      run_access(0, 1, 32'h7777_8888);

      // Randomized mix against the reference model.
      pc = 32'h200;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         a = $urandom & 32'hFFFF_FFFC;
         if (kind == 0) begin
            set_instr(5'($urandom_range(1, 31)), pc, 2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0, 0);
            run_nonmem();
         end else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
            if (kind == 2) f3 = f3 % 4;
            if (f3 % 4 == 0) a = a + $urandom_range(0, 3);
            else if (f3 % 4 == 1) a = a + 2 * $urandom_range(0, 1);
            if (kind == 1) set_instr(5'($urandom_range(1, 31)), pc, 2'd2, a, $urandom, f3, 1, 0);
            else           set_instr(0, pc, 2'd0, a, $urandom, f3, 0, 1);
            run_access($urandom_range(0, 2), $urandom_range(1, 2), $urandom);
         end
         pc = pc + 4;
      end

      // Reset during WAIT_RSP; a response after reset must be ignored.
      set_instr(12, 32'h400, 2, 32'h6000, 0, 3'b010, 1, 0);
      gnt = 1'b1;
      @(negedge clk);
      check("rw_req", req, 1);
      @(posedge clk); #1;
      gnt = 1'b0;
      check("rw_wait", state_dbg, 1);
      rst_ni = 1'b0;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rw_state", state_dbg, 0);
      check("rw_busy", busy, 0);
      check("rw_rd", rd_wb, 0);
      check("rw_pc", pc_wb, 0);
      rvalid = 1'b1; rdata = 32'hABCD_0123;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(negedge clk);
      check("rw_post_busy", busy, 0);
      check("rw_post_req", req, 0);
      @(posedge clk); #1;
      rvalid = 1'b0;
      check("rw_post_state", state_dbg, 0);
      check("rw_post_rd_data", rd_data_wb, 0);
      check("rw_post_ld", is_load_wb, 0);
      check("rw_post_berr", berr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
